// File: rtl/mips_processor.sv
// Single-cycle 32-bit MIPS integer core with internal big-endian instruction and data memories.
// One instruction commits per rising clock edge.

package mips_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_e;

  typedef struct packed {
    logic    reg_write;
    dst_e    dst_sel;
    logic    imm_sel;
    logic    zero_ext;
    logic    mem_write;
    logic    mem_read;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    link;
    logic    jr;
    alu_op_e alu_op;
  } ctrl_t;
endpackage

module control
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl_c
);
  // Anything not decoded below leaves every write enable low.
  always_comb begin
    ctrl_c.reg_write = 1'b0;
    ctrl_c.dst_sel   = DST_RT;
    ctrl_c.imm_sel   = 1'b0;
    ctrl_c.zero_ext  = 1'b0;
    ctrl_c.mem_write = 1'b0;
    ctrl_c.mem_read  = 1'b0;
    ctrl_c.beq       = 1'b0;
    ctrl_c.bne       = 1'b0;
    ctrl_c.jump      = 1'b0;
    ctrl_c.link      = 1'b0;
    ctrl_c.jr        = 1'b0;
    ctrl_c.alu_op    = ALU_ADD;
    case (opcode)
      6'h00: begin
        ctrl_c.dst_sel   = DST_RD;
        ctrl_c.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: ctrl_c.alu_op = ALU_ADD;
          6'h22, 6'h23: ctrl_c.alu_op = ALU_SUB;
          6'h24:        ctrl_c.alu_op = ALU_AND;
          6'h25:        ctrl_c.alu_op = ALU_OR;
          6'h26:        ctrl_c.alu_op = ALU_XOR;
          6'h27:        ctrl_c.alu_op = ALU_NOR;
          6'h2A:        ctrl_c.alu_op = ALU_SLT;
          6'h2B:        ctrl_c.alu_op = ALU_SLTU;
          6'h00:        ctrl_c.alu_op = ALU_SLL;
          6'h02:        ctrl_c.alu_op = ALU_SRL;
          6'h03:        ctrl_c.alu_op = ALU_SRA;
          6'h08: begin
            ctrl_c.jr        = 1'b1;
            ctrl_c.reg_write = 1'b0;
          end
          default:      ctrl_c.reg_write = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; end
      6'h0A: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.alu_op = ALU_SLT; end
      6'h0C: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.zero_ext = 1'b1; ctrl_c.alu_op = ALU_AND; end
      6'h0D: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.zero_ext = 1'b1; ctrl_c.alu_op = ALU_OR; end
      6'h0E: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.zero_ext = 1'b1; ctrl_c.alu_op = ALU_XOR; end
      6'h0F: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.zero_ext = 1'b1; ctrl_c.alu_op = ALU_LUI; end
      6'h23: begin ctrl_c.reg_write = 1'b1; ctrl_c.imm_sel = 1'b1; ctrl_c.mem_read = 1'b1; end
      6'h2B: begin ctrl_c.imm_sel = 1'b1; ctrl_c.mem_write = 1'b1; end
      6'h04: ctrl_c.beq = 1'b1;
      6'h05: ctrl_c.bne = 1'b1;
      6'h02: ctrl_c.jump = 1'b1;
      6'h03: begin
        ctrl_c.jump      = 1'b1;
        ctrl_c.link      = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.dst_sel   = DST_RA;
      end
      default: ;
    endcase
  end
endmodule

module alu
  import mips_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result_c
);
  // Shifts operate on b (rt); lui places the zero-extended immediate in the upper half.
  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_XOR:  result_c = a ^ b;
      ALU_NOR:  result_c = ~(a | b);
      ALU_SLT:  result_c = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result_c = {31'd0, a < b};
      ALU_SLL:  result_c = b << shamt;
      ALU_SRL:  result_c = b >> shamt;
      ALU_SRA:  result_c = 32'($signed(b) >>> shamt);
      ALU_LUI:  result_c = {b[15:0], 16'd0};
      default:  result_c = '0;
    endcase
  end
endmodule

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1_c,
  output logic [31:0] rd2_c
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1_c = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2_c = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module ins_mem (
  input  logic        clk,
  input  logic        load_en,
  input  logic [9:0]  load_addr,
  input  logic [7:0]  load_data,
  input  logic [7:0]  word_addr,
  output logic [31:0] instr_c
);
  logic [7:0] memory [0:1023];

  // Byte load port for in-system programming; the core itself never drives it.
  always @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign instr_c = {memory[{word_addr, 2'd0}], memory[{word_addr, 2'd1}],
                    memory[{word_addr, 2'd2}], memory[{word_addr, 2'd3}]};
endmodule

module data_mem (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  word_addr,
  input  logic [31:0] wd,
  output logic [31:0] rd_c
);
  logic [7:0] memory [0:1023];

  always @(posedge clk) begin
    if (we) begin
      memory[{word_addr, 2'd0}] <= wd[31:24];
      memory[{word_addr, 2'd1}] <= wd[23:16];
      memory[{word_addr, 2'd2}] <= wd[15:8];
      memory[{word_addr, 2'd3}] <= wd[7:0];
    end
  end

  assign rd_c = {memory[{word_addr, 2'd0}], memory[{word_addr, 2'd1}],
                 memory[{word_addr, 2'd2}], memory[{word_addr, 2'd3}]};
endmodule

module mips_processor
  import mips_pkg::*;
(
  input logic clk,
  input logic reset
);
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc, pc_plus4, pc_next, instr, rd1, rd2, imm_ext, alu_b, alu_result, dmem_rd, wd;
  logic [4:0]      wa;
  logic            taken;
  ctrl_t           ctrl;

  ins_mem my_ins_mem (
    .clk(clk), .load_en(1'b0), .load_addr(10'd0), .load_data(8'd0),
    .word_addr(pc[9:2]), .instr_c(instr)
  );

  control ctrl_unit (.opcode(instr[31:26]), .funct(instr[5:0]), .ctrl_c(ctrl));

  reg_file reg_file (
    .clk(clk), .reset(reset), .ra1(instr[25:21]), .ra2(instr[20:16]),
    .we(ctrl.reg_write), .wa(wa), .wd(wd), .rd1_c(rd1), .rd2_c(rd2)
  );

  assign imm_ext = ctrl.zero_ext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign alu_b   = ctrl.imm_sel ? imm_ext : rd2;

  alu alu_unit (.op(ctrl.alu_op), .a(rd1), .b(alu_b), .shamt(instr[10:6]), .result_c(alu_result));

  // Stores are suppressed on a reset edge so memory survives a mid-run reset.
  data_mem data_mem (
    .clk(clk), .we(ctrl.mem_write && reset), .word_addr(alu_result[9:2]),
    .wd(rd2), .rd_c(dmem_rd)
  );

  always_comb begin
    wa = instr[20:16];
    case (ctrl.dst_sel)
      DST_RD:  wa = instr[15:11];
      DST_RA:  wa = 5'd31;
      default: wa = instr[20:16];
    endcase
  end

  assign wd       = ctrl.link ? pc_plus4 : (ctrl.mem_read ? dmem_rd : alu_result);
  assign pc_plus4 = pc + 32'd4;
  assign taken    = (ctrl.beq && (rd1 == rd2)) || (ctrl.bne && (rd1 != rd2));

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jr)        pc_next = rd1;
    else if (ctrl.jump) pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (taken)     pc_next = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end
endmodule

// File: tb/tb_mips_processor.sv
// Self-checking bench for mips_processor: preloads memories, runs short programs and
// compares architectural state against expectations queued when each program is loaded.

module tb_mips_processor;
  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;
  logic [31:0] obs;

  mips_processor dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 1024; i++) begin
      dut.my_ins_mem.memory[i] = 8'h00;
      dut.data_mem.memory[i]   = 8'h00;
    end
  endtask

  task automatic load_ins(input int addr, input logic [31:0] w);
    dut.my_ins_mem.memory[addr]   = w[31:24];
    dut.my_ins_mem.memory[addr+1] = w[23:16];
    dut.my_ins_mem.memory[addr+2] = w[15:8];
    dut.my_ins_mem.memory[addr+3] = w[7:0];
  endtask

  function automatic logic [31:0] dmem_word(input int addr);
    return {dut.data_mem.memory[addr], dut.data_mem.memory[addr+1],
            dut.data_mem.memory[addr+2], dut.data_mem.memory[addr+3]};
  endfunction

  // Hold reset low across one edge, then release so the next edge executes word 0.
  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_mems();
    step(2);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", dut.pc, exp); end
    for (int i = 0; i < 32; i++) begin
      exp = exp_q.pop_front(); n_checks++;
      obs = dut.reg_file.registers[i];
      if (obs !== exp) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", i, obs, exp); end
    end
    reset = 1'b1;
  endtask

  task automatic test_jal_jr();
    clear_mems();
    load_ins(0, 32'h0C000005);
    load_ins(20, 32'h03E00008);
    do_reset();
    exp_q.push_back(32'd20); exp_q.push_back(32'd4); exp_q.push_back(32'd4);
    step(1);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL jal_pc: got %h expected %h", dut.pc, exp); end
    exp = exp_q.pop_front(); n_checks++;
    obs = dut.reg_file.registers[31];
    if (obs !== exp) begin n_fail++; $display("FAIL jal_ra: got %h expected %h", obs, exp); end
    step(1);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL jr_pc: got %h expected %h", dut.pc, exp); end
  endtask

  task automatic test_loads();
    clear_mems();
    dut.data_mem.memory[7] = 8'h28;
    load_ins(0, 32'h8C110004);  // lw $17,4($0)
    load_ins(4, 32'h8C100000);  // lw $16,0($0)
    load_ins(8, 32'h8C120404);  // lw $18,1028($0) wraps to 4
    do_reset();
    exp_q.push_back(32'd40); exp_q.push_back(32'd0); exp_q.push_back(32'd40);
    step(1);
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[17];
    if (obs !== exp) begin n_fail++; $display("FAIL lw_s1: got %h expected %h", obs, exp); end
    step(1);
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[16];
    if (obs !== exp) begin n_fail++; $display("FAIL lw_s0: got %h expected %h", obs, exp); end
    step(1);
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[18];
    if (obs !== exp) begin n_fail++; $display("FAIL lw_wrap: got %h expected %h", obs, exp); end
  endtask

  task automatic test_addi_store();
    clear_mems();
    load_ins(0, 32'h20080000);
    load_ins(4, 32'h21080001);
    load_ins(8, 32'hAC080008);
    do_reset();
    exp_q.push_back(32'h00000001); exp_q.push_back(32'd1);
    step(3);
    exp = exp_q.pop_front(); n_checks++; obs = dmem_word(8);
    if (obs !== exp) begin n_fail++; $display("FAIL sw_word: got %h expected %h", obs, exp); end
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[8];
    if (obs !== exp) begin n_fail++; $display("FAIL addi_t0: got %h expected %h", obs, exp); end
  endtask

  task automatic test_branches();
    logic [31:0] t1_init [3] = '{32'h20090001, 32'h2009000A, 32'h2009000A};
    logic [31:0] br_ins  [3] = '{32'h15240002, 32'h15240002, 32'h11240002};
    logic [31:0] next_pc [3] = '{32'd24, 32'd16, 32'd24};
    for (int c = 0; c < 3; c++) begin
      clear_mems();
      load_ins(0, t1_init[c]);
      load_ins(4, 32'h2004000A);
      load_ins(12, br_ins[c]);
      do_reset();
      exp_q.push_back(32'd12); exp_q.push_back(next_pc[c]);
      step(3);
      exp = exp_q.pop_front(); n_checks++;
      if (dut.pc !== exp) begin n_fail++; $display("FAIL branch%0d_pre: got %h expected %h", c, dut.pc, exp); end
      step(1);
      exp = exp_q.pop_front(); n_checks++;
      if (dut.pc !== exp) begin n_fail++; $display("FAIL branch%0d_next: got %h expected %h", c, dut.pc, exp); end
    end
  endtask

  task automatic test_rtype();
    int          idx [9] = '{8, 10, 11, 12, 14, 0, 15, 16, 17};
    logic [31:0] val [9] = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'hF8000000,
                             32'd0, 32'd2, 32'h0000FFFF, 32'd0};
    logic [31:0] prog [12] = '{32'h2008FFFF, 32'h20090001, 32'h01095020, 32'h0109582A,
                               32'h0109602B, 32'h3C0D8000, 32'h000D7103, 32'h01080020,
                               32'h20000005, 32'h01287822, 32'h3410FFFF, 32'hFC111234};
    clear_mems();
    for (int i = 0; i < 12; i++) load_ins(4 * i, prog[i]);
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(val[i]);
    exp_q.push_back(32'd48);
    step(12);
    for (int i = 0; i < 9; i++) begin
      exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[idx[i]];
      if (obs !== exp) begin n_fail++; $display("FAIL rtype_reg%0d: got %h expected %h", idx[i], obs, exp); end
    end
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL unknown_op_pc: got %h expected %h", dut.pc, exp); end
  endtask

  task automatic test_reset_mid_run();
    clear_mems();
    load_ins(0, 32'h20080001);   // addi $8,$0,1
    load_ins(4, 32'h21080001);   // addi $8,$8,1
    load_ins(8, 32'hAC080020);   // sw $8,32($0)
    load_ins(12, 32'h08000001);  // j 4
    do_reset();
    step(11);
    exp_q.push_back(32'd8); exp_q.push_back(32'd5);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL midrun_pc: got %h expected %h", dut.pc, exp); end
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[8];
    if (obs !== exp) begin n_fail++; $display("FAIL midrun_t0: got %h expected %h", obs, exp); end
    // Reset lands on the edge where sw is pending; the stored word must stay 4.
    reset = 1'b0;
    step(1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    for (int i = 0; i < 32; i++) exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", dut.pc, exp); end
    exp = exp_q.pop_front(); n_checks++; obs = dmem_word(32);
    if (obs !== exp) begin n_fail++; $display("FAIL rst_dmem: got %h expected %h", obs, exp); end
    for (int i = 0; i < 32; i++) begin
      exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[i];
      if (obs !== exp) begin n_fail++; $display("FAIL rst_reg%0d: got %h expected %h", i, obs, exp); end
    end
    reset = 1'b1;
    exp_q.push_back(32'd4); exp_q.push_back(32'd1);
    step(1);
    exp = exp_q.pop_front(); n_checks++;
    if (dut.pc !== exp) begin n_fail++; $display("FAIL restart_pc: got %h expected %h", dut.pc, exp); end
    exp = exp_q.pop_front(); n_checks++; obs = dut.reg_file.registers[8];
    if (obs !== exp) begin n_fail++; $display("FAIL restart_t0: got %h expected %h", obs, exp); end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_jal_jr();
    test_loads();
    test_addi_store();
    test_branches();
    test_rtype();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
